// File: rtl/fraction_normalizer.sv
// fraction_normalizer
// Left-normalizes a 26-bit fraction so that bit 25 is set, decrementing the
// paired biased exponent by the same amount. The shift stops early if the
// exponent reaches zero (underflow) or the fraction is all zeros (zero).
//
// Build option: define NORM_FAST_SHIFT_EN to replace the 1-bit-per-cycle
// iteration with a single-cycle leading-zero-count shift. Results and flags
// are identical in both builds; only the latency differs.
//
// Timing: start sampled at edge E0 (IDLE). done rises at E(k+2) for the
// iterative build (k = applied shift, or 0 for a zero fraction), E2 for the
// fast build. done is high in the IDLE cycle following the DONE state, so a
// new start presented alongside done is accepted on the next edge.
module fraction_normalizer #(
   parameter int EXP_W = 8
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             start,
   input  logic [25:0]      fraction_in,
   input  logic [EXP_W-1:0] exponent_in,
   output logic             busy,
   output logic             done,
   output logic [25:0]      fraction_out,
   output logic [EXP_W-1:0] exponent_out,
   output logic [4:0]       shift_count,
   output logic             zero,
   output logic             underflow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [25:0]      frac_q, frac_d;
   logic [EXP_W-1:0] exp_q, exp_d;
   logic [4:0]       cnt_q, cnt_d;
   logic             zero_q, zero_d;
   logic             unf_q, unf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

`ifdef NORM_FAST_SHIFT_EN
   localparam int CMP_W = (EXP_W > 5) ? EXP_W : 5;

   logic [4:0]       lzc_w;
   logic [CMP_W-1:0] lzc_ext, exp_ext, amt_w;
   logic             exhaust_w;

   // Leading-zero count of a 26-bit word; 26 when the word is zero.
   function automatic logic [4:0] lzc26(input logic [25:0] v);
      logic [4:0] n;
      n = 5'd26;
      for (int i = 0; i < 26; i++) begin
         if (v[i]) n = 5'(25 - i);
      end
      return n;
   endfunction

   // Full shift amount: leading zeros, clipped by the available exponent.
   always_comb begin
      lzc_w     = lzc26(frac_q);
      lzc_ext   = CMP_W'(lzc_w);
      exp_ext   = CMP_W'(exp_q);
      exhaust_w = (lzc_ext > exp_ext);
      amt_w     = exhaust_w ? exp_ext : lzc_ext;
   end
`endif

   // Next-state and datapath update for the normalize FSM.
   always_comb begin
      state_d = state_q;
      frac_d  = frac_q;
      exp_d   = exp_q;
      cnt_d   = cnt_q;
      zero_d  = zero_q;
      unf_d   = unf_q;
      done_d  = (state_q == DONE);

      case (state_q)
         IDLE: begin
            if (start) begin
               frac_d  = fraction_in;
               exp_d   = exponent_in;
               cnt_d   = 5'd0;
               zero_d  = 1'b0;
               unf_d   = 1'b0;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            if (frac_q == 26'd0) begin
               zero_d  = 1'b1;
               frac_d  = 26'd0;
               exp_d   = '0;
               cnt_d   = 5'd0;
               state_d = DONE;
            end
`ifdef NORM_FAST_SHIFT_EN
            else begin
               frac_d  = frac_q << amt_w[4:0];
               exp_d   = exp_q - amt_w[EXP_W-1:0];
               cnt_d   = amt_w[4:0];
               unf_d   = exhaust_w;
               state_d = DONE;
            end
`else
            else if (frac_q[25]) begin
               state_d = DONE;
            end else if (exp_q == '0) begin
               unf_d   = 1'b1;
               state_d = DONE;
            end else begin
               frac_d  = {frac_q[24:0], 1'b0};
               exp_d   = exp_q - EXP_W'(1);
               cnt_d   = cnt_q + 5'd1;
            end
`endif
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == SHIFT) || (state_d == DONE);
   end

   // State and result registers; reset clears everything visible at the ports.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         frac_q  <= 26'd0;
         exp_q   <= '0;
         cnt_q   <= 5'd0;
         zero_q  <= 1'b0;
         unf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         frac_q  <= frac_d;
         exp_q   <= exp_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
         unf_q   <= unf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign fraction_out = frac_q;
   assign exponent_out = exp_q;
   assign shift_count  = cnt_q;
   assign zero         = zero_q;
   assign underflow    = unf_q;

endmodule

// File: tb/tb_fraction_normalizer.sv
// Scoreboard bench for fraction_normalizer: stimulus pushes reference results,
// a negedge monitor pops and compares whenever done is seen.
module tb_fraction_normalizer;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        start = 1'b0;
   logic [25:0] fraction_in = 26'd0;
   logic [7:0]  exponent_in = 8'd0;
   logic        busy, done, zero, underflow;
   logic [25:0] fraction_out;
   logic [7:0]  exponent_out;
   logic [4:0]  shift_count;

   fraction_normalizer #(.EXP_W(8)) dut (
      .CLK(CLK), .nRST(nRST), .start(start),
      .fraction_in(fraction_in), .exponent_in(exponent_in),
      .busy(busy), .done(done), .fraction_out(fraction_out),
      .exponent_out(exponent_out), .shift_count(shift_count),
      .zero(zero), .underflow(underflow)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [25:0] frac;
      logic [7:0]  expo;
      logic [4:0]  cnt;
      logic        zero;
      logic        unf;
      int          due;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   logic done_prev = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: shift = min(leading zeros, exponent); zero fraction is special.
   function automatic exp_t model(input logic [25:0] f, input logic [7:0] e);
      exp_t r;
      int lz, sh, lat;
      lz = 0;
      while (lz < 26 && f[25-lz] == 1'b0) lz++;
      if (f == 26'd0) begin
         r.frac = 26'd0; r.expo = 8'd0; r.cnt = 5'd0; r.zero = 1'b1; r.unf = 1'b0;
         lat = 2;
      end else begin
         sh = (lz < int'(e)) ? lz : int'(e);
         r.frac = f << sh;
         r.expo = 8'(int'(e) - sh);
         r.cnt  = 5'(sh);
         r.zero = 1'b0;
         r.unf  = (lz > int'(e));
`ifdef NORM_FAST_SHIFT_EN
         lat = 2;
`else
         lat = sh + 2;
`endif
      end
      r.due = lat;
      return r;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge CLK) begin
      if (nRST && done) begin
         check("done_width", done_prev, 0);
         if (q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("fraction_out", fraction_out, e.frac);
            check("exponent_out", exponent_out, e.expo);
            check("shift_count", shift_count, e.cnt);
            check("zero", zero, e.zero);
            check("underflow", underflow, e.unf);
            check("done_latency_edge", cyc, e.due);
            check("busy_low_at_done", busy, 0);
         end
      end
      done_prev = done;
   end

   // Present one operation (called at a negedge); returns at the negedge where
   // done is seen, having optionally hammered start with junk while busy.
   task automatic run_op(input logic [25:0] f, input logic [7:0] e, input bit junk);
      exp_t r;
      int   n;
      r = model(f, e);
      start = 1'b1; fraction_in = f; exponent_in = e;
      @(posedge CLK); #1;
      r.due = cyc + r.due;
      q.push_back(r);
      check("busy_after_start", busy, 1);
      @(negedge CLK);
      start = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         if (junk) begin
            start = 1'b1;
            fraction_in = 26'($urandom);
            exponent_in = 8'($urandom);
         end
         @(negedge CLK);
         start = 1'b0;
         n++;
      end
      if (!done) check("done_timeout", 0, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [25:0] f;
      logic [7:0]  e;
      int          lz;

      #13;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_fraction_out", fraction_out, 0);
      check("rst_exponent_out", exponent_out, 0);
      check("rst_shift_count", shift_count, 0);
      check("rst_zero", zero, 0);
      check("rst_underflow", underflow, 0);
      @(negedge CLK);
      nRST = 1'b1;
      @(negedge CLK);

      // Directed corner cases; junk start while busy on some.
      run_op(26'h2000000, 8'h80, 1'b0);
      run_op(26'h0000001, 8'h80, 1'b1);
      run_op(26'h0010000, 8'h03, 1'b1);
      run_op(26'h0000000, 8'h55, 1'b0);
      run_op(26'h0000004, 8'h17, 1'b0);
      run_op(26'h1234567, 8'h00, 1'b0);
      @(negedge CLK);
      @(negedge CLK);

      // Reset in the middle of a shift sequence.
      start = 1'b1; fraction_in = 26'h0000100; exponent_in = 8'h80;
      q.push_back(model(26'h0000100, 8'h80));
      @(negedge CLK);
      start = 1'b0;
      repeat (4) @(negedge CLK);
      #2;
      nRST = 1'b0;
      q.delete();
      #1;
      check("midrst_fraction_out", fraction_out, 0);
      check("midrst_exponent_out", exponent_out, 0);
      check("midrst_shift_count", shift_count, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      @(negedge CLK);
      nRST = 1'b1;
      repeat (3) @(negedge CLK);
      check("postrst_busy", busy, 0);
      run_op(26'h0000100, 8'h80, 1'b0);

      // Randomized operations, mostly back-to-back.
      for (int i = 0; i < 60; i++) begin
         lz = $urandom_range(0, 26);
         if (lz == 26) f = 26'd0;
         else f = (26'h2000000 >> lz) | (26'($urandom) & ((26'h2000000 >> lz) - 26'd1));
         e = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 30)) : 8'($urandom);
         if ($urandom_range(0, 3) == 0) @(negedge CLK);
         run_op(f, e, ($urandom_range(0, 1) == 1));
      end

      repeat (5) @(negedge CLK);
      check("scoreboard_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
